// File: rtl/i2c_defs.sv
// Shared definitions for the I2C register slave: FSM states, device address default,
// and bus-level ACK/NACK values.
package i2c_defs;

    typedef enum logic [3:0] {
        StIdle,
        StDev,
        StDevAck,
        StSub,
        StSubAck,
        StWr,
        StWrAck,
        StRd,
        StRdAck,
        StWait
    } state_t;

    localparam logic [7:0]  DEV_ADDR_DEFAULT = 8'h72;
    localparam logic        ACK              = 1'b0;
    localparam logic        NACK             = 1'b1;
    localparam int unsigned FILT_CNT_W       = 3;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a counter glitch filter; the output only follows the
// input after FILT_LEN consecutive equal synchronized samples. Resets to the idle-high level.
module i2c_line_filter
    import i2c_defs::*;
#(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_out
);

    logic [1:0]            sync_q;
    logic [FILT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            line_out <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_in};
            if (sync_q[1] == line_out) begin
                cnt_q <= '0;
            end else if (cnt_q == FILT_CNT_W'(FILT_LEN - 1)) begin
                line_out <= sync_q[1];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target with an 8-bit sub-address pointer: single/burst register writes and
// pointer-based reads through an external register port. Never stretches SCL.
module i2c_reg_slave
    import i2c_defs::*;
#(
    parameter logic [7:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       oREG_WE,
    output logic [7:0] oREG_ADDR,
    output logic [7:0] oREG_WDATA,
    input  logic [7:0] iREG_RDATA,
    output logic       oBUSY
);

    logic       scl_f, sda_f;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_rise, scl_fall, start_det, stop_det;
    state_t     state_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] rx_byte;
    logic [2:0] rd_idx;
    logic       last_bit;
    logic       rw_q;
    logic       sda_oe_q;

    i2c_line_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_scl_filt (
        .clk      (iCLK),
        .rst_n    (iRST_N),
        .line_in  (I2C_SCLK),
        .line_out (scl_f)
    );

    i2c_line_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_sda_filt (
        .clk      (iCLK),
        .rst_n    (iRST_N),
        .line_in  (I2C_SDAT),
        .line_out (sda_f)
    );

    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

    assign rx_byte  = {shift_q[6:0], sda_f};
    assign last_bit = (bit_cnt_q == 4'd7);
    assign rd_idx   = 3'd7 - bit_cnt_q[2:0];

    // Open drain: the output enable is registered, so an async reset releases the line at once.
    assign I2C_SDAT = sda_oe_q ? ACK : 1'bz;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            oREG_WE    <= 1'b0;
            oREG_ADDR  <= '0;
            oREG_WDATA <= '0;
            oBUSY      <= 1'b0;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
            oREG_WE    <= 1'b0;
            if (stop_det) begin
                state_q  <= StIdle;
                sda_oe_q <= 1'b0;
                oBUSY    <= 1'b0;
            end else if (start_det) begin
                state_q   <= StDev;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                oBUSY     <= 1'b0;
            end else begin
                case (state_q)
                    StDev: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (last_bit) begin
                                bit_cnt_q <= '0;
                                if (rx_byte[7:1] == DEV_ADDR[7:1]) begin
                                    state_q <= StDevAck;
                                    rw_q    <= rx_byte[0];
                                    oBUSY   <= 1'b1;
                                end else begin
                                    state_q <= StIdle;
                                end
                            end
                        end
                    end
                    // In the ACK states the first fall starts the drive, the second ends the slot.
                    StDevAck: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else if (rw_q) begin
                                state_q   <= StRd;
                                shift_q   <= iREG_RDATA;
                                sda_oe_q  <= ~iREG_RDATA[7];
                                bit_cnt_q <= '0;
                            end else begin
                                state_q  <= StSub;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    StSub: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (last_bit) begin
                                bit_cnt_q <= '0;
                                oREG_ADDR <= rx_byte;
                                state_q   <= StSubAck;
                            end
                        end
                    end
                    StSubAck: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StWr;
                            end
                        end
                    end
                    StWr: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (last_bit) begin
                                bit_cnt_q  <= '0;
                                oREG_WDATA <= rx_byte;
                                oREG_WE    <= 1'b1;
                                state_q    <= StWrAck;
                            end
                        end
                    end
                    StWrAck: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                oREG_ADDR <= oREG_ADDR + 8'd1;
                                state_q   <= StWr;
                            end
                        end
                    end
                    // bit_cnt_q counts bits already clocked out to the master.
                    StRd: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StRdAck;
                            end else begin
                                sda_oe_q <= ~shift_q[rd_idx];
                            end
                        end
                    end
                    // bit_cnt_q == 9 marks "master acknowledged, reload on next fall".
                    StRdAck: begin
                        if (scl_rise) begin
                            if (sda_f == NACK) begin
                                state_q <= StWait;
                                oBUSY   <= 1'b0;
                            end else begin
                                oREG_ADDR <= oREG_ADDR + 8'd1;
                                bit_cnt_q <= 4'd9;
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd9) begin
                            shift_q   <= iREG_RDATA;
                            sda_oe_q  <= ~iREG_RDATA[7];
                            bit_cnt_q <= '0;
                            state_q   <= StRd;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
